norm_shifter: RTL and testbench

- Multi-cycle normalizer. It runs the barrel shift in reverse: from an operand it finds the shift amount that normalizes it, and returns both the normalized word and that amount.
- Binary-search left normalization, one search step per clock, with valid/ready handshakes on both sides.
- Used ahead of the datapath shifter for count-leading-zeros/sign bits and for fixed-point normalization.
- Round-trip property: shifting data_o right by amt_o (logical for unsigned, arithmetic for signed) reproduces data_i.

---
 rtl/norm_shifter.sv | 137 +++++++++++++
 tb/tb_norm_shifter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/norm_shifter.sv
// Iterative left normalizer: binary-searches the shift that brings the operand
// to normalized form (leading one, or single sign bit) and returns word + amount.
module norm_shifter #(
    parameter int WIDTH = 32,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic [AMT_W-1:0] amt_o,
    output logic             zero_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [AMT_W-1:0] HALF_W    = AMT_W'(WIDTH / 2);
    localparam logic [AMT_W-1:0] LAST_STEP = AMT_W'(AMT_W - 1);
    localparam logic [AMT_W:0]   WIDTH_X   = (AMT_W + 1)'(WIDTH);
    localparam logic [AMT_W:0]   ONE_X     = (AMT_W + 1)'(1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic               mode_q, mode_d;
    logic [AMT_W-1:0]   amt_q, amt_d;
    logic [AMT_W-1:0]   step_q, step_d;
    logic               opz_q, opz_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [AMT_W-1:0]   amt_out_q, amt_out_d;
    logic               zero_out_q, zero_out_d;

    logic [AMT_W-1:0]   w;
    logic [AMT_W:0]     w_x;
    logic [WIDTH-1:0]   top_u, top_s, mask_s;
    logic               hit;
    logic [WIDTH-1:0]   x_step;
    logic [AMT_W-1:0]   amt_step;

    // One search step: test whether the top w bits (unsigned) or top w+1 bits
    // (signed) are redundant, and if so commit a shift of w.
    always_comb begin
        w        = HALF_W >> step_q;
        w_x      = {1'b0, w};
        top_u    = x_q >> (WIDTH_X - w_x);
        top_s    = x_q >> (WIDTH_X - w_x - ONE_X);
        mask_s   = ~({WIDTH{1'b1}} << (w_x + ONE_X));
        hit      = mode_q ? ((top_s == '0) || (top_s == mask_s)) : (top_u == '0);
        x_step   = hit ? (x_q << w) : x_q;
        amt_step = hit ? (amt_q + w) : amt_q;
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        mode_d     = mode_q;
        amt_d      = amt_q;
        step_d     = step_q;
        opz_d      = opz_q;
        data_d     = data_q;
        amt_out_d  = amt_out_q;
        zero_out_d = zero_out_q;

        case (state_q)
            IDLE: begin
                if (valid_i && ready_q) begin
                    x_d     = data_i;
                    mode_d  = mode_i;
                    amt_d   = '0;
                    step_d  = '0;
                    opz_d   = (data_i == '0);
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d    = x_step;
                amt_d  = amt_step;
                step_d = step_q + AMT_W'(1);
                if (step_q == LAST_STEP) begin
                    data_d     = x_step;
                    amt_out_d  = amt_step;
                    zero_out_d = opz_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            amt_q      <= '0;
            step_q     <= '0;
            opz_q      <= 1'b0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            data_q     <= '0;
            amt_out_q  <= '0;
            zero_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            mode_q     <= mode_d;
            amt_q      <= amt_d;
            step_q     <= step_d;
            opz_q      <= opz_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            amt_out_q  <= amt_out_d;
            zero_out_q <= zero_out_d;
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign amt_o   = amt_out_q;
    assign zero_o  = zero_out_q;

endmodule

// File: tb/tb_norm_shifter.sv
// Randomized bench for norm_shifter against a count-leading-bits reference model.
module tb_norm_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic        mode_i;
    logic [31:0] data_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] data_o;
    logic [4:0]  amt_o;
    logic        zero_o;

    int n_chk  = 0;
    int n_pass = 0;

    norm_shifter #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .mode_i  (mode_i),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .amt_o   (amt_o),
        .zero_o  (zero_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Reference: amount = number of redundant leading bits, capped at 31.
    function automatic void ref_norm(input logic m, input logic [31:0] d,
                                     output logic [31:0] nd, output int amt);
        int n = 0;
        if (!m) begin
            while (n < 31 && d[31-n] == 1'b0) n++;
        end else begin
            while (n < 31 && d[30-n] == d[31]) n++;
        end
        amt = n;
        nd  = d << n;
    endfunction

    task automatic op(input logic m, input logic [31:0] d, input int hold, input bit pulse,
                      output logic [31:0] od, output logic [4:0] oa, output logic oz);
        logic [31:0]        ed;
        int                 ea;
        int                 n;
        int                 lat;
        logic signed [31:0] s;
        ref_norm(m, d, ed, ea);
        n = 0;
        while (!ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(ready_o), 32'd1);
        valid_i = 1'b1;
        mode_i  = m;
        data_i  = d;
        @(negedge clk);
        valid_i = 1'b0;
        mode_i  = ~m;
        data_i  = $urandom;
        lat = 0;
        while (!valid_o && lat < 20) begin
            if (pulse) begin
                chk("ready_busy", 32'(ready_o), 32'd0);
                valid_i = 1'($urandom);
                data_i  = $urandom;
            end
            @(negedge clk);
            lat++;
        end
        valid_i = 1'b0;
        chk("latency", 32'(lat), 32'd5);
        od = data_o;
        oa = amt_o;
        oz = zero_o;
        chk("data", od, ed);
        chk("amt", 32'(oa), 32'(ea));
        chk("zero", 32'(oz), 32'(d == 32'd0));
        if (!m) begin
            chk("roundtrip_u", od >> oa, d);
            if (!oz) chk("inv_u", 32'(od[31]), 32'd1);
        end else begin
            s = od;
            chk("roundtrip_s", 32'(s >>> oa), d);
            if (!oz && d != 32'hFFFF_FFFF) chk("inv_s", 32'(od[31] ^ od[30]), 32'd1);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(valid_o), 32'd1);
            chk("hold_data", data_o, od);
            chk("hold_amt", 32'(amt_o), 32'(oa));
            chk("hold_zero", 32'(zero_o), 32'(oz));
            chk("hold_ready", 32'(ready_o), 32'd0);
        end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        chk("valid_drop", 32'(valid_o), 32'd0);
        chk("ready_back", 32'(ready_o), 32'd1);
    endtask

    initial begin
        logic [31:0] od;
        logic [4:0]  oa;
        logic        oz;
        logic [31:0] d;
        rst     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        mode_i  = 1'b0;
        data_i  = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_data", data_o, 32'd0);
        chk("rst_amt", 32'(amt_o), 32'd0);
        chk("rst_zero", 32'(zero_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        op(1'b0, 32'h0000_0001, 0, 1'b0, od, oa, oz);
        chk("t1_data", od, 32'h8000_0000);
        chk("t1_amt", 32'(oa), 32'd31);
        op(1'b1, 32'h0000_0001, 0, 1'b0, od, oa, oz);
        chk("t2a_data", od, 32'h4000_0000);
        chk("t2a_amt", 32'(oa), 32'd30);
        op(1'b1, 32'hFFFF_FFF0, 0, 1'b0, od, oa, oz);
        chk("t2b_data", od, 32'h8000_0000);
        chk("t2b_amt", 32'(oa), 32'd27);
        op(1'b0, 32'h0000_0000, 0, 1'b0, od, oa, oz);
        chk("t3a_amt", 32'(oa), 32'd31);
        chk("t3a_zero", 32'(oz), 32'd1);
        op(1'b1, 32'h0000_0000, 0, 1'b0, od, oa, oz);
        chk("t3b_amt", 32'(oa), 32'd31);
        chk("t3b_zero", 32'(oz), 32'd1);
        op(1'b1, 32'hFFFF_FFFF, 0, 1'b0, od, oa, oz);
        chk("t3c_data", od, 32'h8000_0000);
        chk("t3c_amt", 32'(oa), 32'd31);
        chk("t3c_zero", 32'(oz), 32'd0);
        op(1'b0, 32'h8000_0000, 0, 1'b0, od, oa, oz);
        chk("t3d_data", od, 32'h8000_0000);
        chk("t3d_amt", 32'(oa), 32'd0);
        op(1'b1, 32'hA000_0000, 4, 1'b1, od, oa, oz);
        chk("t4_amt", 32'(oa), 32'd0);

        // Reset two steps into a run must abandon it
        valid_i = 1'b1;
        mode_i  = 1'b0;
        data_i  = 32'h0001_2345;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rrun_ready", 32'(ready_o), 32'd1);
        chk("rrun_valid", 32'(valid_o), 32'd0);
        chk("rrun_data", data_o, 32'd0);
        chk("rrun_amt", 32'(amt_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rrun_quiet", 32'(valid_o), 32'd0);
        end
        op(1'b0, 32'h00F0_0000, 0, 1'b0, od, oa, oz);
        chk("t5_data", od, 32'hF000_0000);
        chk("t5_amt", 32'(oa), 32'd8);

        for (int md = 0; md < 2; md++) begin
            for (int k = 0; k < 2500; k++) begin
                case ($urandom_range(0, 15))
                    0:       d = 32'h0000_0000;
                    1:       d = 32'hFFFF_FFFF;
                    default: d = $urandom >> $urandom_range(0, 31);
                endcase
                if (md == 1 && $urandom_range(0, 1) == 1) d = ~d;
                op(1'(md), d, $urandom_range(0, 1), 1'($urandom_range(0, 1)), od, oa, oz);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
